// File: rtl/sfifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// The optional sticky error flags are built when SFIFO_ERR_EN is defined.
package sfifo_pkg;

    // Registered status flags, all derived from the next occupancy count
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    // Status immediately after reset or flush: nothing stored
    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, almost_full: 1'b0,
                                           empty: 1'b1, almost_empty: 1'b1};

    // Explicit wrap so that any depth works, not only powers of two
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Legal parameter combinations for the FIFO
    function automatic bit params_ok(input int depth, input int af_thresh, input int ae_thresh);
        return (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh < depth);
    endfunction

endpackage

// File: rtl/sfifo_param_if.sv
// Producer/consumer bus of the parametrised FIFO.
// Overflow/underflow/clr_err exist only when SFIFO_ERR_EN is defined.
//
// Handshake: wren is the write valid; the write is taken on a rising edge
// when the FIFO is not full, or when it is full and a read is taken in the
// same cycle. rden is the read request; a pop happens when not empty.
// Requests that are not taken leave the FIFO unchanged, so the producer must
// hold wren/wdata until it sees room (full low) if it does not want to lose data.
interface sfifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wren;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rden;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic [CW-1:0]         count;
`ifdef SFIFO_ERR_EN
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (output flush, wren, wdata, rden, clr_err,
                    input  rdata, full, almost_full, empty, almost_empty, count,
                           overflow, underflow);
    modport slave  (input  flush, wren, wdata, rden, clr_err,
                    output rdata, full, almost_full, empty, almost_empty, count,
                           overflow, underflow);
`else
    modport master (output flush, wren, wdata, rden,
                    input  rdata, full, almost_full, empty, almost_empty, count);
    modport slave  (input  flush, wren, wdata, rden,
                    output rdata, full, almost_full, empty, almost_empty, count);
`endif

endinterface

// File: rtl/sfifo_wrap_ptr.sv
// Wrapping pointer for the FIFO; counts 0..DEPTH-1 and wraps explicitly.
// clr (flush) takes priority over inc.
module sfifo_wrap_ptr
    import sfifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;

    // Next pointer: clear, advance with wrap, or hold
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = PW'(next_ptr(32'(ptr_q), 32'(DEPTH)));
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with show-ahead read data, occupancy count,
// almost-full/almost-empty thresholds and synchronous flush.
// Optional sticky overflow/underflow flags: define SFIFO_ERR_EN.
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic         clk,
    input  logic         arst_n,
    sfifo_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
        $error("sfifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  rd_acc, wr_acc;

    // A read is taken only when something is stored; a write on full only alongside a taken read
    assign rd_acc = bus.rden & ~flags_q.empty;
    assign wr_acc = bus.wren & (~flags_q.full | rd_acc);

    sfifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (bus.flush),
        .inc    (wr_acc),
        .ptr    (wr_ptr)
    );

    sfifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (bus.flush),
        .inc    (rd_acc),
        .ptr    (rd_ptr)
    );

    // Storage write; not reset, contents are meaningless once pointers are cleared
    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end

    // Next occupancy and the flags derived from it
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        flags_d.full         = (count_d == CW'(DEPTH));
        flags_d.almost_full  = (32'(count_d) >= AF_THRESH);
        flags_d.empty        = (count_d == '0);
        flags_d.almost_empty = (32'(count_d) <= AE_THRESH);
    end

    // Occupancy and flag registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
            flags_q <= FLAGS_RESET;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    assign bus.rdata        = mem[rd_ptr];
    assign bus.count        = count_q;
    assign bus.full         = flags_q.full;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_empty = flags_q.almost_empty;

`ifdef SFIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a new rejection wins over a clear in the same cycle
    always_comb begin
        overflow_d  = (bus.wren & ~wr_acc) | (overflow_q & ~bus.clr_err);
        underflow_d = (bus.rden & flags_q.empty) | (underflow_q & ~bus.clr_err);
    end

    // Error flag registers; flush leaves them alone
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Bench for sfifo_param with DEPTH=5, AF_THRESH=4, AE_THRESH=1.
// Error-flag checks are compiled in when SFIFO_ERR_EN is defined.
module tb_sfifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    sfifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sfifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic       wren;
        logic [7:0] wdata;
        logic       rden;
        logic       flush;
        int         exp_count;
        logic       chk_rdata;
        logic [7:0] exp_rdata;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected occupancy plus the flags the thresholds give for it
    task automatic check_state(input string name, input int c, input logic chk, input logic [7:0] head);
        check({name, " count"}, 32'(bus.count), 32'(c));
        check({name, " full"}, 32'(bus.full), 32'(c == 5));
        check({name, " almost_full"}, 32'(bus.almost_full), 32'(c >= 4));
        check({name, " empty"}, 32'(bus.empty), 32'(c == 0));
        check({name, " almost_empty"}, 32'(bus.almost_empty), 32'(c <= 1));
        if (chk) check({name, " rdata"}, 32'(bus.rdata), 32'(head));
    endtask

    task automatic drive_idle();
        bus.wren  = 1'b0;
        bus.wdata = '0;
        bus.rden  = 1'b0;
        bus.flush = 1'b0;
`ifdef SFIFO_ERR_EN
        bus.clr_err = 1'b0;
`endif
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge
    task automatic op(input logic w, input logic [7:0] d, input logic r, input logic f);
        bus.wren  = w;
        bus.wdata = d;
        bus.rden  = r;
        bus.flush = f;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic add(input string name, input logic w, input logic [7:0] d, input logic r,
                       input logic f, input int c, input logic chk, input logic [7:0] h);
        vec_t v;
        v.name = name; v.wren = w; v.wdata = d; v.rden = r; v.flush = f;
        v.exp_count = c; v.chk_rdata = chk; v.exp_rdata = h;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] base;
        drive_idle();
        repeat (2) @(negedge clk);
        check_state("in_reset", 0, 1'b0, 8'h00);
        arst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state("after_reset", 0, 1'b0, 8'h00);

        // Fill to full, then an extra write that is dropped
        add("t1_w11", 1, 8'h11, 0, 0, 1, 1, 8'h11);
        add("t1_w22", 1, 8'h22, 0, 0, 2, 1, 8'h11);
        add("t1_w33", 1, 8'h33, 0, 0, 3, 1, 8'h11);
        add("t1_w44", 1, 8'h44, 0, 0, 4, 1, 8'h11);
        add("t1_w55", 1, 8'h55, 0, 0, 5, 1, 8'h11);
        add("t1_w66", 1, 8'h66, 0, 0, 5, 1, 8'h11);
        // Drain in order
        add("t2_r1", 0, 8'h00, 1, 0, 4, 1, 8'h22);
        add("t2_r2", 0, 8'h00, 1, 0, 3, 1, 8'h33);
        add("t2_r3", 0, 8'h00, 1, 0, 2, 1, 8'h44);
        add("t2_r4", 0, 8'h00, 1, 0, 1, 1, 8'h55);
        add("t2_r5", 0, 8'h00, 1, 0, 0, 0, 8'h00);
        // Pointers wrap several times
        for (int g = 0; g < 4; g++) begin
            base = 8'hA0 + 8'(g * 16);
            for (int j = 0; j < 3; j++)
                add($sformatf("t3_g%0d_w%0d", g, j), 1, base + 8'(j), 0, 0, j + 1, 1, base);
            for (int j = 1; j <= 3; j++)
                add($sformatf("t3_g%0d_r%0d", g, j), 0, 8'h00, 1, 0, 3 - j, (j < 3), base + 8'(j));
        end
        // Simultaneous read/write on full, then on empty
        add("t4_w31", 1, 8'h31, 0, 0, 1, 1, 8'h31);
        add("t4_w32", 1, 8'h32, 0, 0, 2, 1, 8'h31);
        add("t4_w33", 1, 8'h33, 0, 0, 3, 1, 8'h31);
        add("t4_w34", 1, 8'h34, 0, 0, 4, 1, 8'h31);
        add("t4_w35", 1, 8'h35, 0, 0, 5, 1, 8'h31);
        add("t4_full_both", 1, 8'h36, 1, 0, 5, 1, 8'h32);
        add("t4_r1", 0, 8'h00, 1, 0, 4, 1, 8'h33);
        add("t4_r2", 0, 8'h00, 1, 0, 3, 1, 8'h34);
        add("t4_r3", 0, 8'h00, 1, 0, 2, 1, 8'h35);
        add("t4_r4", 0, 8'h00, 1, 0, 1, 1, 8'h36);
        add("t4_r5", 0, 8'h00, 1, 0, 0, 0, 8'h00);
        add("t4_empty_both", 1, 8'h77, 1, 0, 1, 1, 8'h77);
        add("t4_r6", 0, 8'h00, 1, 0, 0, 0, 8'h00);
        // Flush overrides a simultaneous write
        add("t5_wc1", 1, 8'hC1, 0, 0, 1, 1, 8'hC1);
        add("t5_wc2", 1, 8'hC2, 0, 0, 2, 1, 8'hC1);
        add("t5_wc3", 1, 8'hC3, 0, 0, 3, 1, 8'hC1);
        add("t5_flush", 1, 8'h99, 0, 1, 0, 0, 8'h00);
        add("t5_wab", 1, 8'hAB, 0, 0, 1, 1, 8'hAB);
        add("t5_rab", 0, 8'h00, 1, 0, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            op(vecs[i].wren, vecs[i].wdata, vecs[i].rden, vecs[i].flush);
            check_state(vecs[i].name, vecs[i].exp_count, vecs[i].chk_rdata, vecs[i].exp_rdata);
        end

        // Asynchronous reset in the middle of a burst
        op(1, 8'hD1, 0, 0);
        op(1, 8'hD2, 0, 0);
        check_state("t5_pre_rst", 2, 1'b1, 8'hD1);
        bus.wren  = 1'b1;
        bus.wdata = 8'hD3;
        #2;
        arst_n = 1'b0;
        #1;
        check_state("t5_async_rst", 0, 1'b0, 8'h00);
        @(negedge clk);
        drive_idle();
        arst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state("t5_post_rst", 0, 1'b0, 8'h00);
        op(1, 8'hCD, 0, 0);
        check_state("t5_wcd", 1, 1'b1, 8'hCD);
        op(0, 8'h00, 1, 0);
        check_state("t5_rcd", 0, 1'b0, 8'h00);

        // Rejected write on full and rejected read on empty
        for (int k = 0; k < 5; k++) op(1, 8'hE1 + 8'(k), 0, 0);
        check_state("t6_full", 5, 1'b1, 8'hE1);
        op(1, 8'hEE, 0, 0);
        check_state("t6_ovf_write", 5, 1'b1, 8'hE1);
`ifdef SFIFO_ERR_EN
        check("t6_overflow_set", 32'(bus.overflow), 32'd1);
        check("t6_underflow_clear", 32'(bus.underflow), 32'd0);
        op(0, 8'h00, 0, 0);
        check("t6_overflow_held", 32'(bus.overflow), 32'd1);
`endif
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t6_drain%0d rdata", k), 32'(bus.rdata), 32'(8'hE1 + 8'(k)));
            op(0, 8'h00, 1, 0);
        end
        check_state("t6_drained", 0, 1'b0, 8'h00);
        op(0, 8'h00, 1, 0);
        check_state("t6_udf_read", 0, 1'b0, 8'h00);
`ifdef SFIFO_ERR_EN
        check("t6_underflow_set", 32'(bus.underflow), 32'd1);
        op(0, 8'h00, 0, 1);
        check("t6_flush_keeps_udf", 32'(bus.underflow), 32'd1);
        // Clear together with another empty read: set wins for underflow
        bus.clr_err = 1'b1;
        op(0, 8'h00, 1, 0);
        check("t6_setwins_udf", 32'(bus.underflow), 32'd1);
        check("t6_clr_ovf", 32'(bus.overflow), 32'd0);
        bus.clr_err = 1'b1;
        op(0, 8'h00, 0, 0);
        check("t6_clr_udf", 32'(bus.underflow), 32'd0);
        check("t6_clr_ovf2", 32'(bus.overflow), 32'd0);
`endif
        op(1, 8'h5A, 0, 0);
        check_state("t6_after", 1, 1'b1, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
